// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: turns opcode/field requests into 32-bit words,
// buffers them in a 2-entry FIFO and tags each with an instruction-memory address.
module instr_encoder #(
  parameter int unsigned AW        = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op_sel,
  input  logic [4:0]    rd,
  input  logic [4:0]    rn,
  input  logic [4:0]    rm,
  input  logic [18:0]   imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   instr,
  output logic [AW-1:0] addr,
  output logic          err
);

  localparam int unsigned IW = 32;

  localparam logic [2:0] OP_LDUR = 3'd0;
  localparam logic [2:0] OP_STUR = 3'd1;
  localparam logic [2:0] OP_CBZ  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_ORR  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  logic [1:0]    count_q, count_d;
  logic [IW-1:0] ent0_q, ent0_d;
  logic [IW-1:0] ent1_q, ent1_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic [1:0]    fill_c;
  logic [IW-1:0] word_c;

  // D-format ignores rm and imm[18:9], CB ignores rn/rm, R ignores imm.
  function automatic logic [IW-1:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rn,
    input logic [4:0]  f_rm,
    input logic [18:0] f_imm
  );
    logic [IW-1:0] w;
    w = '0;
    case (op)
      OP_LDUR: w = {11'b11111000010, f_imm[8:0], 2'b00, f_rn, f_rd};
      OP_STUR: w = {11'b11111000000, f_imm[8:0], 2'b00, f_rn, f_rd};
      OP_CBZ:  w = {8'b10110100, f_imm, f_rd};
      OP_ADD:  w = {11'b10001011000, f_rm, 6'b000000, f_rn, f_rd};
      OP_SUB:  w = {11'b11001011000, f_rm, 6'b000000, f_rn, f_rd};
      OP_AND:  w = {11'b10001010000, f_rm, 6'b000000, f_rn, f_rd};
      OP_ORR:  w = {11'b10101010000, f_rm, 6'b000000, f_rn, f_rd};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Shift FIFO: entry 0 is always the head, so instr comes straight off a flop.
  always_comb begin
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    accept_c = in_valid && in_ready_q;
    push_c   = accept_c && (op_sel != OP_ILL);
    pop_c    = out_valid_q && out_ready;
    word_c   = encode(op_sel, rd, rn, rm, imm);
    fill_c   = count_q - 2'(pop_c);

    if (pop_c) begin
      ent0_d = ent1_q;
      addr_d = addr_q + AW'(1);
    end
    if (push_c) begin
      if (fill_c == 2'd0) ent0_d = word_c;
      else                ent1_d = word_c;
    end

    count_d     = fill_c + 2'(push_c);
    err_d       = accept_c && (op_sel == OP_ILL);
    // Handshake flags are registered from the next count, so out_ready never reaches in_ready combinationally.
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= 2'd0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      addr_q      <= AW'(BASE_ADDR);
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign instr     = ent0_q;
  assign addr      = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (AW=6 and AW=2) share stimulus and are
// checked every cycle against a queue-based reference plus fixed vectors.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  op_sel;
  logic [4:0]  rd, rn, rm;
  logic [18:0] imm;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_err;
  logic [31:0] a_instr;
  logic [5:0]  a_addr;
  logic        b_in_ready, b_out_valid, b_err;
  logic [31:0] b_instr;
  logic [1:0]  b_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(6), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .out_valid(a_out_valid), .out_ready(out_ready), .instr(a_instr),
    .addr(a_addr), .err(a_err)
  );

  instr_encoder #(.AW(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .out_valid(b_out_valid), .out_ready(out_ready), .instr(b_instr),
    .addr(b_addr), .err(b_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding from the field layout, built with shifts and masks.
  function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] d,
                                          input logic [4:0] n, input logic [4:0] m,
                                          input logic [18:0] i);
    int unsigned ropc [4];
    int unsigned w;
    ropc = '{32'h458, 32'h658, 32'h450, 32'h550};
    case (op)
      3'd0:    w = (32'h7C2 << 21) | ((32'(i) & 32'h1FF) << 12) | (32'(n) << 5) | 32'(d);
      3'd1:    w = (32'h7C0 << 21) | ((32'(i) & 32'h1FF) << 12) | (32'(n) << 5) | 32'(d);
      3'd2:    w = (32'hB4 << 24) | (32'(i) << 5) | 32'(d);
      3'd7:    w = 0;
      default: w = (ropc[32'(op) - 3] << 21) | (32'(m) << 16) | (32'(n) << 5) | 32'(d);
    endcase
    return 32'(w);
  endfunction

  // Reference model: a word queue, a pop counter for the address and an err flag.
  logic [31:0] mq [$];
  bit          m_init = 1'b0;
  int          m_pops = 0;
  bit          m_err  = 1'b0;
  bit          m_acc;
  bit          checking = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_init = 1'b0;
      m_pops = 0;
      m_err  = 1'b0;
    end else begin
      m_acc = in_valid && m_init && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) begin
        void'(mq.pop_front());
        m_pops++;
      end
      if (m_acc && op_sel != 3'd7) mq.push_back(ref_enc(op_sel, rd, rn, rm, imm));
      m_err  = m_acc && (op_sel == 3'd7);
      m_init = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("a_in_ready", 32'(a_in_ready), 32'(m_init && mq.size() < 2));
      chk("b_in_ready", 32'(b_in_ready), 32'(m_init && mq.size() < 2));
      chk("a_out_valid", 32'(a_out_valid), 32'(mq.size() > 0));
      chk("b_out_valid", 32'(b_out_valid), 32'(mq.size() > 0));
      chk("a_err", 32'(a_err), 32'(m_err));
      chk("b_err", 32'(b_err), 32'(m_err));
      chk("a_addr", 32'(a_addr), 32'(m_pops % 64));
      chk("b_addr", 32'(b_addr), 32'(m_pops % 4));
      if (mq.size() > 0) begin
        chk("a_instr", a_instr, mq[0]);
        chk("b_instr", b_instr, mq[0]);
      end else if (!reset) begin
        chk("a_instr_rst", a_instr, 32'h0);
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [18:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t        tv [10];
  logic [31:0] w0, w1, w2;

  task automatic set_req(input logic v, input logic [2:0] o, input logic [4:0] d,
                         input logic [4:0] n, input logic [4:0] m, input logic [18:0] i);
    in_valid = v; op_sel = o; rd = d; rn = n; rm = m; imm = i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    step();
  endtask

  initial begin
    tv[0] = '{3'd3, 5'd1, 5'd2, 5'd3, 19'd0,       32'h8B030041};
    tv[1] = '{3'd0, 5'd9, 5'd10, 5'd0, 19'd8,      32'hF8408149};
    tv[2] = '{3'd1, 5'd1, 5'd2, 5'd0, 19'd0,       32'hF8000041};
    tv[3] = '{3'd2, 5'd5, 5'd0, 5'd0, 19'd3,       32'hB4000065};
    tv[4] = '{3'd2, 5'd5, 5'd0, 5'd0, 19'h7FFFF,   32'hB4FFFFE5};
    tv[5] = '{3'd4, 5'd1, 5'd2, 5'd3, 19'd0,       32'hCB030041};
    tv[6] = '{3'd5, 5'd1, 5'd2, 5'd3, 19'd0,       32'h8A030041};
    tv[7] = '{3'd6, 5'd1, 5'd2, 5'd3, 19'd0,       32'hAA030041};
    tv[8] = '{3'd0, 5'd9, 5'd10, 5'd31, 19'h7FE08, 32'hF8408149};
    tv[9] = '{3'd3, 5'd1, 5'd2, 5'd3, 19'h7FFFF,   32'h8B030041};

    reset = 1'b0;
    out_ready = 1'b0;
    set_req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0);
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'h0);
    chk("rst_addr", 32'(a_addr), 32'h0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 32'(a_in_ready), 32'h0);
    step();
    chk("rdy_after_edge", 32'(a_in_ready), 32'h1);

    // Single ADD with the sink ready: latency one, then the address advances.
    out_ready = 1'b1;
    set_req(1'b1, 3'd3, 5'd1, 5'd2, 5'd3, 19'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", 32'(a_out_valid), 32'h1);
    chk("add_instr", a_instr, 32'h8B030041);
    chk("add_addr0", 32'(a_addr), 32'h0);
    @(negedge clk);
    chk("add_valid_after", 32'(a_out_valid), 32'h0);
    chk("add_addr1", 32'(a_addr), 32'h1);

    for (int k = 0; k < 10; k++) begin
      step();
      set_req(1'b1, tv[k].op, tv[k].rd, tv[k].rn, tv[k].rm, tv[k].imm);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), 32'(a_out_valid), 32'h1);
      chk($sformatf("vec%0d_instr", k), a_instr, tv[k].exp);
    end

    // Backpressure: two words fill the FIFO, the third waits for space.
    do_reset();
    out_ready = 1'b0;
    w0 = 32'hF8408149; w1 = 32'hCB030041; w2 = 32'hB4000065;
    set_req(1'b1, 3'd0, 5'd9, 5'd10, 5'd0, 19'd8);
    step();
    set_req(1'b1, 3'd4, 5'd1, 5'd2, 5'd3, 19'd0);
    step();
    set_req(1'b1, 3'd2, 5'd5, 5'd0, 5'd0, 19'd3);
    @(negedge clk);
    chk("bp_full_rdy", 32'(a_in_ready), 32'h0);
    repeat (2) step();
    @(negedge clk);
    chk("bp_hold_instr", a_instr, w0);
    chk("bp_hold_addr", 32'(a_addr), 32'h0);
    chk("bp_hold_rdy", 32'(a_in_ready), 32'h0);
    step();
    out_ready = 1'b1;
    step();
    chk("bp_w1", a_instr, w1);
    chk("bp_a1", 32'(a_addr), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_w2", a_instr, w2);
    chk("bp_a2", 32'(a_addr), 32'h2);
    step();
    chk("bp_empty", 32'(a_out_valid), 32'h0);
    chk("bp_a3", 32'(a_addr), 32'h3);

    // Illegal opcode: single-cycle err pulse and nothing queued.
    set_req(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 19'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_err", 32'(a_err), 32'h1);
    chk("ill_valid", 32'(a_out_valid), 32'h0);
    @(negedge clk);
    chk("ill_err_gone", 32'(a_err), 32'h0);

    // Address wrap on the narrow instance.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b1, 3'd5, 5'(k), 5'd2, 5'd3, 19'd0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("wrap_addr%0d", k), 32'(b_addr), 32'(k % 4));
      step();
    end

    // Reset with two words buffered clears the outputs at once.
    out_ready = 1'b0;
    set_req(1'b1, 3'd6, 5'd7, 5'd8, 5'd9, 19'd0);
    repeat (2) step();
    in_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'h0);
    chk("mid_rst_addr", 32'(a_addr), 32'h0);
    chk("mid_rst_rdy", 32'(a_in_ready), 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    step();

    // Reset clears a pending err pulse.
    set_req(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_err_clear", 32'(a_err), 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    step();

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom),
              5'($urandom), 5'($urandom), 19'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter AW, default 6: width of the instruction-memory write address.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first write address after reset.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 SHALL have port in_valid  input  1: request fields are valid.
REQ-006 SHALL have port in_ready  output  1: encoder can accept a request.
REQ-007 SHALL have port op_sel  input  3: 0=LDUR, 1=STUR, 2=CBZ, 3=ADD, 4=SUB, 5=AND, 6=ORR, 7=illegal.
REQ-008 SHALL have ports rd, rn, rm  input  5 each: Rd/Rt, Rn and Rm register numbers.
REQ-009 SHALL have port imm  input  19: CBZ uses imm[18:0]; LDUR/STUR use imm[8:0] as DT_address.
REQ-010 SHALL have port out_valid  output  1: instr and addr hold a valid word.
REQ-011 SHALL have port out_ready  input  1: sink accepts the word.
REQ-012 SHALL have port instr  output  32: encoded LEGv8 instruction.
REQ-013 SHALL have port addr  output  AW: instruction-memory word address for instr.
REQ-014 SHALL have port err  output  1: one-cycle pulse when an illegal request is accepted.

Function
REQ-015 Input transfer SHALL occur on an edge with in_valid=1 and in_ready=1; output transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-016 SHALL buffer encoded words in a 2-entry FIFO; in_ready=1 when fewer than 2 entries are held, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 when the FIFO is non-empty; instr SHALL show the head entry. A word accepted at edge N SHALL appear on out_valid after edge N (latency 1) when the FIFO was empty.
REQ-018 Push and pop on the same edge with 1 entry held SHALL leave the count at 1. A push and pop on the same edge with 2 entries held SHALL NOT occur, because in_ready=0 when full.
REQ-019 instr and addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 LDUR SHALL encode as {11'b11111000010, imm[8:0], 2'b00, rn, rd}; STUR SHALL use opcode 11'b11111000000 with the same field layout.
REQ-021 CBZ SHALL encode as {8'b10110100, imm[18:0], rd}.
REQ-022 R-format SHALL encode as {opcode, rm, 6'b000000, rn, rd}.
REQ-023 R-format opcodes SHALL be ADD=11'b10001011000, SUB=11'b11001011000, AND=11'b10001010000 and ORR=11'b10101010000.
REQ-024 Unused input bits SHALL be ignored: rm for D/CB types, imm for R type, imm[18:9] for D type.
REQ-025 op_sel=7 SHALL still be accepted while in_ready=1; it SHALL be discarded with no FIFO push and err=1 for the following cycle only.
REQ-026 addr SHALL be an AW-bit write counter, starting at BASE_ADDR, incremented by 1 on each output transfer.
REQ-027 addr SHALL wrap from 2^AW-1 to 0 with no flag or stall; addr is the address of the current head word.

Reset
REQ-028 While reset=0, the FIFO SHALL be emptied.
REQ-029 Reset output values SHALL be: out_valid=0, in_ready=0, instr=0, err=0, addr=BASE_ADDR.
REQ-030 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words with no output transfer; a pending err pulse SHALL be cleared.

Verification
REQ-032 op_sel=3, rd=1, rn=2, rm=3, single request, out_ready=1 -> next cycle out_valid=1, instr=0x8B030041, addr=0; the following cycle addr=1 and out_valid=0.
REQ-033 op_sel=0, rd=9, rn=10, imm=8 -> instr=0xF8408149.
REQ-034 op_sel=1, rd=1, rn=2, imm=0 -> instr=0xF8000041.
REQ-035 op_sel=2, rd=5, imm=3 -> instr=0xB4000065; with imm=0x7FFFF the word is 0xB4FFFFE5.
REQ-036 Backpressure: out_ready=0, three back-to-back requests -> two accepted, in_ready=0 from the edge after the second push; releasing out_ready yields the words in order at addr 0,1; the third word is then accepted and output at addr 2.
REQ-037 op_sel=7 -> err high for exactly one cycle, no out_valid; with AW=2, five legal words are written at addr 0,1,2,3,0; reset=0 with 2 entries buffered -> out_valid=0 immediately, addr=0.
